// File: rtl/lsu_mem_stage_if.sv
// LSU bundles: core-side request/response and data-memory bus.
// master drives requests; slave answers them.
interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_funct3,
        output req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata,
        input  resp_err, busy
    );
    modport slave (
        input  req_valid, req_we, req_funct3,
        input  req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata,
        output resp_err, busy
    );
endinterface

interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_req, mem_we, mem_addr,
        output mem_wdata, mem_be,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
    modport slave (
        input  mem_req, mem_we, mem_addr,
        input  mem_wdata, mem_be,
        output mem_gnt, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit: one data-memory transaction per accepted op,
// returning an extended load result or store ack to writeback.
module lsu_mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      reset,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);
    typedef enum logic [1:0] {
        IDLE, ACCESS, WAIT, RESP
    } state_t;

    localparam logic [7:0] CMAX = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_f3;
    logic [1:0]  r_off;
    logic [31:0] r_maddr;
    logic [31:0] r_mwdata;
    logic [3:0]  r_mbe;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_accept;
    logic        w_done;
    logic        w_tmo;
    logic        w_illegal;
    logic        w_misal;
    logic        w_bad;
    logic [2:0]  w_f3;
    logic [1:0]  w_off;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_f3     = req.req_funct3;
    assign w_off    = req.req_addr[1:0];
    assign w_accept = (r_state == IDLE) && req.req_valid;
    assign w_done   = (r_state == WAIT) && mem.mem_rvalid;
    assign w_tmo    = (r_cnt == CMAX);

    // Classify the offered op: bad ops never touch the bus.
    always_comb begin
        if (req.req_we) begin
            w_illegal = (w_f3 >= 3'b011);
        end else begin
            w_illegal = (w_f3 == 3'b011) || (w_f3 == 3'b110) ||
                        (w_f3 == 3'b111);
        end
        w_misal = ((w_f3[1:0] == 2'b01) && w_off[0]) ||
                  ((w_f3[1:0] == 2'b10) && (w_off != 2'b00));
        w_bad   = w_illegal || w_misal;
    end

    // Store lane replication and byte enables; loads read the whole word.
    always_comb begin
        w_wdata = 32'h0;
        w_be    = 4'b1111;
        if (req.req_we) begin
            unique case (1'b1)
                (w_f3[1:0] == 2'b00): begin
                    w_wdata = {4{req.req_wdata[7:0]}};
                    w_be    = 4'b0001 << w_off;
                end
                (w_f3[1:0] == 2'b01): begin
                    w_wdata = {2{req.req_wdata[15:0]}};
                    w_be    = w_off[1] ? 4'b1100 : 4'b0011;
                end
                default: w_wdata = req.req_wdata;
            endcase
        end
    end

    // Pick the addressed byte/half out of the returned word and extend it.
    always_comb begin
        unique case (r_off)
            2'd0: w_byte = mem.mem_rdata[7:0];
            2'd1: w_byte = mem.mem_rdata[15:8];
            2'd2: w_byte = mem.mem_rdata[23:16];
            2'd3: w_byte = mem.mem_rdata[31:24];
        endcase
        w_half = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        w_ext  = mem.mem_rdata;
        unique case (1'b1)
            (r_f3 == 3'b000): w_ext = {{24{w_byte[7]}}, w_byte};
            (r_f3 == 3'b001): w_ext = {{16{w_half[15]}}, w_half};
            (r_f3 == 3'b100): w_ext = {24'h0, w_byte};
            (r_f3 == 3'b101): w_ext = {16'h0, w_half};
            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next state; the grant or rvalid wins over a same-cycle timeout.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:   if (req.req_valid) w_next = w_bad ? RESP : ACCESS;
            ACCESS: if (mem.mem_gnt)   w_next = WAIT;
                    else if (w_tmo)    w_next = RESP;
            WAIT:   if (mem.mem_rvalid || w_tmo) w_next = RESP;
            RESP:   w_next = IDLE;
        endcase
    end

    // State-decoded outputs; mem_req falls with an async reset.
    always_comb begin
        req.req_ready = (r_state == IDLE);
        req.busy      = (r_state != IDLE);
        mem.mem_req   = (r_state == ACCESS);
    end

    // Cycle budget shared by ACCESS and WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= 8'h0;
        end else if ((r_state == ACCESS) || (r_state == WAIT)) begin
            r_cnt <= r_cnt + 8'h1;
        end else begin
            r_cnt <= 8'h0;
        end
    end

    // Latch the op and its bus image at accept; held until the next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we     <= 1'b0;
            r_f3     <= 3'b0;
            r_off    <= 2'b0;
            r_maddr  <= 32'h0;
            r_mwdata <= 32'h0;
            r_mbe    <= 4'h0;
        end else if (w_accept) begin
            r_we     <= req.req_we;
            r_f3     <= w_f3;
            r_off    <= w_off;
            r_maddr  <= {req.req_addr[31:2], 2'b00};
            r_mwdata <= w_wdata;
            r_mbe    <= w_be;
        end
    end

    // Registered one-cycle response; everything but a clean load reads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'h0;
        end else begin
            r_resp_valid <= (w_next == RESP);
            r_resp_err   <= (w_next == RESP) &&
                            (!w_done || mem.mem_err);
            r_resp_rdata <= (w_done && !mem.mem_err && !r_we) ?
                            w_ext : 32'h0;
        end
    end

    assign mem.mem_we     = r_we;
    assign mem.mem_addr   = r_maddr;
    assign mem.mem_wdata  = r_mwdata;
    assign mem.mem_be     = r_mbe;
    assign req.resp_valid = r_resp_valid;
    assign req.resp_rdata = r_resp_rdata;
    assign req.resp_err   = r_resp_err;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed scenarios plus random ops
// against a rule-level reference model.
module tb_lsu_mem_stage;
    localparam int TMO = 8;

    logic clk;
    logic reset;
    int   nvec;
    int   nerr;

    lsu_req_if rq();
    lsu_mem_if mb();

    lsu_mem_stage #(.TIMEOUT(TMO)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (rq),
        .mem   (mb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rule-level model of one op: legality, bus image, load value.
    task automatic model(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  logic [31:0] rd,
        output logic        bad,
        output logic [3:0]  ebe,
        output logic [31:0] ewd,
        output logic [31:0] eval
    );
        int off;
        int sh;
        logic [31:0] v;
        off = int'(addr % 4);
        if (we) bad = (f3 > 3'd2);
        else    bad = (f3 == 3'd3) || (f3 > 3'd5);
        if ((f3 == 3'd1 || f3 == 3'd5) && (off % 2 == 1)) bad = 1'b1;
        if (f3 == 3'd2 && off != 0) bad = 1'b1;
        ebe = 4'd15;
        ewd = 32'h0;
        if (we) begin
            if (f3 == 3'd0) begin
                ebe = 4'(1 << off);
                ewd = (wd & 32'hFF) * 32'h0101_0101;
            end else if (f3 == 3'd1) begin
                ebe = (off >= 2) ? 4'd12 : 4'd3;
                ewd = (wd & 32'hFFFF) * 32'h0001_0001;
            end else begin
                ewd = wd;
            end
        end
        v = rd;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (rd >> (8 * off)) & 32'hFF;
            if (f3 == 3'd0 && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            sh = (off >= 2) ? 16 : 0;
            v = (rd >> sh) & 32'hFFFF;
            if (f3 == 3'd1 && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end
        eval = we ? 32'h0 : v;
    endtask

    // Drive one op and act as memory; gdly<0 means never grant.
    task automatic run_op(
        input  logic        we,
        input  logic [2:0]  f3,
        input  logic [31:0] addr,
        input  logic [31:0] wd,
        input  int          gdly,
        input  int          rdly,
        input  logic [31:0] rd,
        input  logic        berr,
        input  logic        noise,
        output int          lat,
        output int          reqcyc,
        output logic        stable,
        output logic [31:0] oaddr,
        output logic [31:0] owd,
        output logic [3:0]  obe,
        output logic        owe,
        output logic [31:0] ordata,
        output logic        oerr,
        output logic        got,
        output logic        clean
    );
        int phase;
        int wc;
        lat = 0; reqcyc = 0; stable = 1'b1; got = 1'b0;
        ordata = 32'h0; oerr = 1'b0; clean = 1'b0;
        phase = 0; wc = 0;
        rq.req_valid = 1'b1; rq.req_we = we; rq.req_funct3 = f3;
        rq.req_addr = addr; rq.req_wdata = wd;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        oaddr = mb.mem_addr; owd = mb.mem_wdata;
        obe = mb.mem_be; owe = mb.mem_we;
        for (int c = 1; c < 300; c++) begin
            mb.mem_gnt = 1'b0; mb.mem_rvalid = 1'b0; mb.mem_err = 1'b0;
            if (rq.resp_valid) begin
                lat = c; got = 1'b1;
                ordata = rq.resp_rdata; oerr = rq.resp_err;
                break;
            end
            if (mb.mem_req) begin
                reqcyc++;
                if (mb.mem_addr !== oaddr) stable = 1'b0;
            end
            if (phase == 0 && mb.mem_req) begin
                if (gdly >= 0 && reqcyc == gdly + 1) begin
                    mb.mem_gnt = 1'b1; phase = 1;
                end else if (noise) begin
                    mb.mem_rvalid = 1'b1; mb.mem_rdata = $urandom;
                end
            end else if (phase == 1) begin
                if (wc == rdly) begin
                    mb.mem_rvalid = 1'b1; mb.mem_rdata = rd;
                    mb.mem_err = berr; phase = 2;
                end
                wc++;
            end
            @(posedge clk); #1;
        end
        mb.mem_gnt = 1'b0; mb.mem_rvalid = 1'b0; mb.mem_err = 1'b0;
        @(posedge clk); #1;
        clean = !rq.resp_valid && rq.resp_rdata == 32'h0 &&
                !rq.resp_err && rq.req_ready;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        nvec++;
        if ({rq.resp_valid, rq.resp_rdata, rq.resp_err, mb.mem_req,
             mb.mem_we, mb.mem_addr, mb.mem_wdata, mb.mem_be} !== 72'h0) begin
            nerr++;
            $display("FAIL reset_outputs: got nonzero value(s) v=%b d=%h e=%b rq=%b a=%h be=%h",
                rq.resp_valid, rq.resp_rdata, rq.resp_err, mb.mem_req,
                mb.mem_addr, mb.mem_be);
        end
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;
        nvec++;
        if (rq.req_ready !== 1'b1 || rq.busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_ready: ready=%b busy=%b want 1/0",
                rq.req_ready, rq.busy);
        end
    endtask

    task automatic test_load_byte();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b0, 3'b000, 32'h1003, 32'h0, 0, 0, 32'h80AB_CD12, 1'b0,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (a !== 32'h1000 || be !== 4'b1111 || we !== 1'b0) begin
            nerr++;
            $display("FAIL lb_bus: addr=%h be=%b we=%b want 1000/1111/0", a, be, we);
        end
        nvec++;
        if (!got || d !== 32'hFFFF_FF80 || e !== 1'b0) begin
            nerr++;
            $display("FAIL lb_data: got=%b data=%h err=%b want ffffff80/0", got, d, e);
        end
        nvec++;
        if (lat != 3 || rc != 1 || !cl) begin
            nerr++;
            $display("FAIL lb_timing: lat=%0d reqcyc=%0d clean=%b want 3/1/1", lat, rc, cl);
        end
    endtask

    task automatic test_load_half_u();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b0, 3'b101, 32'h2002, 32'h0, 0, 0, 32'h9ABC_1234, 1'b0,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (!got || d !== 32'h0000_9ABC || e !== 1'b0 || a !== 32'h2000) begin
            nerr++;
            $display("FAIL lhu: data=%h err=%b addr=%h want 00009abc/0/2000", d, e, a);
        end
    endtask

    task automatic test_store();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b1, 3'b000, 32'h11, 32'h1234_56A5, 0, 0, 32'hFFFF_FFFF,
               1'b0, 1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (w !== 32'hA5A5_A5A5 || be !== 4'b0010 || we !== 1'b1 || a !== 32'h10) begin
            nerr++;
            $display("FAIL sb_bus: wdata=%h be=%b we=%b addr=%h want a5a5a5a5/0010/1/10",
                w, be, we, a);
        end
        run_op(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, 0, 0, 32'hFFFF_FFFF,
               1'b0, 1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (w !== 32'hBEEF_BEEF || be !== 4'b1100) begin
            nerr++;
            $display("FAIL sh_bus: wdata=%h be=%b want beefbeef/1100", w, be);
        end
        nvec++;
        if (!got || d !== 32'h0 || e !== 1'b0 || lat != 3) begin
            nerr++;
            $display("FAIL sh_resp: data=%h err=%b lat=%0d want 0/0/3", d, e, lat);
        end
    endtask

    task automatic test_misaligned_illegal();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b0, 3'b010, 32'h102, 32'h0, 0, 0, 32'h1234_5678, 1'b0,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (!got || lat != 1 || rc != 0 || e !== 1'b1 || d !== 32'h0) begin
            nerr++;
            $display("FAIL lw_misaligned: lat=%0d reqcyc=%0d err=%b data=%h want 1/0/1/0",
                lat, rc, e, d);
        end
        run_op(1'b0, 3'b011, 32'h100, 32'h0, 0, 0, 32'h1234_5678, 1'b0,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (!got || lat != 1 || rc != 0 || e !== 1'b1 || d !== 32'h0) begin
            nerr++;
            $display("FAIL ld_illegal: lat=%0d reqcyc=%0d err=%b data=%h want 1/0/1/0",
                lat, rc, e, d);
        end
    endtask

    task automatic test_grant_delay();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b0, 3'b010, 32'h0000_4A40, 32'h0, 3, 0, 32'hCAFE_F00D,
               1'b0, 1'b1, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (rc != 4 || !st || lat != 6) begin
            nerr++;
            $display("FAIL gnt_delay: reqcyc=%0d stable=%b lat=%0d want 4/1/6", rc, st, lat);
        end
        nvec++;
        if (!got || d !== 32'hCAFE_F00D || e !== 1'b0) begin
            nerr++;
            $display("FAIL gnt_delay_data: data=%h err=%b want cafef00d/0", d, e);
        end
    endtask

    task automatic test_timeout();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b0, 3'b010, 32'h80, 32'h0, -1, 0, 32'h0, 1'b0,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (!got || rc != TMO || lat != TMO + 1 || e !== 1'b1 || d !== 32'h0 || !cl) begin
            nerr++;
            $display("FAIL timeout: reqcyc=%0d lat=%0d err=%b data=%h want %0d/%0d/1/0",
                rc, lat, e, d, TMO, TMO + 1);
        end
    endtask

    task automatic test_reset_mid();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        logic seen;
        rq.req_valid = 1'b1; rq.req_we = 1'b0; rq.req_funct3 = 3'b010;
        rq.req_addr = 32'h40; rq.req_wdata = 32'h0;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        reset = 1'b0; #1;
        nvec++;
        if (mb.mem_req !== 1'b0 || rq.busy !== 1'b0) begin
            nerr++;
            $display("FAIL rst_access: mem_req=%b busy=%b want 0/0", mb.mem_req, rq.busy);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        rq.req_valid = 1'b1;
        @(posedge clk); #1;
        rq.req_valid = 1'b0;
        mb.mem_gnt = 1'b1;
        @(posedge clk); #1;
        mb.mem_gnt = 1'b0;
        reset = 1'b0; #1;
        nvec++;
        if (mb.mem_req !== 1'b0 || rq.busy !== 1'b0 || rq.resp_valid !== 1'b0) begin
            nerr++;
            $display("FAIL rst_wait: mem_req=%b busy=%b resp_valid=%b want 0/0/0",
                mb.mem_req, rq.busy, rq.resp_valid);
        end
        reset = 1'b1;
        mb.mem_rvalid = 1'b1; mb.mem_rdata = 32'h5555_AAAA;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            mb.mem_rvalid = 1'b0;
            if (rq.resp_valid || rq.busy) seen = 1'b1;
        end
        nvec++;
        if (seen) begin
            nerr++;
            $display("FAIL late_rvalid: resp_valid/busy seen=%b want 0", seen);
        end
        run_op(1'b0, 3'b010, 32'h44, 32'h0, 0, 1, 32'h0BAD_C0DE, 1'b0,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (!got || d !== 32'h0BAD_C0DE || e !== 1'b0 || lat != 4) begin
            nerr++;
            $display("FAIL post_reset_lw: data=%h err=%b lat=%0d want 0badc0de/0/4", d, e, lat);
        end
    endtask

    task automatic test_bus_err();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        run_op(1'b0, 3'b000, 32'h7, 32'h0, 1, 1, 32'h7F7F_7F7F, 1'b1,
               1'b0, lat, rc, st, a, w, be, we, d, e, got, cl);
        nvec++;
        if (!got || e !== 1'b1 || d !== 32'h0 || lat != 5) begin
            nerr++;
            $display("FAIL bus_err: err=%b data=%h lat=%0d want 1/0/5", e, d, lat);
        end
    endtask

    task automatic test_random();
        int lat, rc; logic st, we, e, got, cl;
        logic [31:0] a, w, d; logic [3:0] be;
        logic rwe, berr, bad, eerr, tout;
        logic [2:0] f3;
        logic [31:0] addr, wd, rd, ewd, eval, erd;
        logic [3:0] ebe;
        int gd, rdl, elat, erc, span;
        for (int n = 0; n < 60; n++) begin
            rwe = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if (n % 3 != 0) f3 = 3'($urandom_range(0, 2)) | (rwe ? 3'd0 : 3'($urandom_range(0, 1) * 4));
            addr = $urandom; wd = $urandom; rd = $urandom;
            berr = ($urandom_range(0, 7) == 0);
            gd = $urandom_range(0, 4); rdl = $urandom_range(0, 4);
            model(rwe, f3, addr, wd, rd, bad, ebe, ewd, eval);
            span = gd + rdl + 2;
            tout = !bad && span > TMO;
            if (bad)       begin elat = 1; erc = 0; end
            else if (tout) begin elat = TMO + 1; erc = (gd + 1 > TMO) ? TMO : gd + 1; end
            else           begin elat = span + 1; erc = gd + 1; end
            eerr = bad || tout || berr;
            erd = eerr ? 32'h0 : eval;
            run_op(rwe, f3, addr, wd, gd, rdl, rd, berr, 1'($urandom_range(0, 1)),
                   lat, rc, st, a, w, be, we, d, e, got, cl);
            nvec++;
            if (!got || lat != elat || rc != erc || !st || !cl) begin
                nerr++;
                $display("FAIL rnd%0d_timing: lat=%0d reqcyc=%0d stable=%b clean=%b want %0d/%0d/1/1",
                    n, lat, rc, st, cl, elat, erc);
            end
            nvec++;
            if (d !== erd || e !== eerr) begin
                nerr++;
                $display("FAIL rnd%0d_resp: we=%b f3=%0d addr=%h data=%h err=%b want %h/%b",
                    n, rwe, f3, addr, d, e, erd, eerr);
            end
            if (!bad) begin
                nvec++;
                if (a !== (addr & 32'hFFFF_FFFC) || be !== ebe || we !== rwe ||
                    (rwe && w !== ewd)) begin
                    nerr++;
                    $display("FAIL rnd%0d_bus: addr=%h be=%b we=%b wdata=%h want %h/%b/%b/%h",
                        n, a, be, we, w, addr & 32'hFFFF_FFFC, ebe, rwe, ewd);
                end
            end
        end
    endtask

    initial begin
        nvec = 0; nerr = 0;
        rq.req_valid = 1'b0; rq.req_we = 1'b0; rq.req_funct3 = 3'b0;
        rq.req_addr = 32'h0; rq.req_wdata = 32'h0;
        mb.mem_gnt = 1'b0; mb.mem_rvalid = 1'b0;
        mb.mem_rdata = 32'h0; mb.mem_err = 1'b0;
        test_reset();
        test_load_byte();
        test_load_half_u();
        test_store();
        test_misaligned_illegal();
        test_grant_delay();
        test_timeout();
        test_reset_mid();
        test_bus_err();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
